instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 145 ++++++++++++++
 tb/tb_instr_encoder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs RV32I field bundles into 32-bit instruction words, stamps each with its byte
// address and queues them in a two-entry FIFO for the instruction-memory writer.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_fmt,
   input  logic [2:0]  in_funct3,
   input  logic        in_funct7b5,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        err_fmt,
   output logic        err_imm,
   input  logic        clr_err,
   input  logic        addr_rst
);

   localparam logic [1:0] FULL = 2'(DEPTH);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] addr;
   } entry_t;

   entry_t             slot0_q, slot0_d, slot1_q, slot1_d, new_entry;
   logic [1:0]         count_q, count_d;
   logic [31:0]        addr_q, addr_d, addr_cur;
   logic               run_q;
   logic               err_fmt_q, err_fmt_d, err_imm_q, err_imm_d;
   logic [31:0]        enc;
   logic               legal, imm_bad;
   logic               fits_i, fits_b, fits_j;
   logic signed [31:0] imm_s;
   logic               accept, push, pop;

   assign imm_s  = in_imm;
   assign fits_i = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
   assign fits_b = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !in_imm[0];
   assign fits_j = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !in_imm[0];

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
   always_comb begin
      enc     = 32'h0;
      legal   = 1'b1;
      imm_bad = 1'b0;
      case (in_fmt)
         3'd0: enc = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
         3'd1: begin
            enc     = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
            imm_bad = !fits_i;
         end
         3'd2: begin
            enc     = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            imm_bad = !fits_i;
         end
         3'd3: begin
            enc     = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
            imm_bad = !fits_i;
         end
         3'd4: begin
            enc     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], OP_BRANCH};
            imm_bad = !fits_b;
         end
         3'd5: begin
            enc     = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
            imm_bad = !fits_j;
         end
         default: legal = 1'b0;
      endcase
   end

   // run_q keeps in_ready low through reset and the release edge itself.
   assign in_ready  = run_q && (count_q != FULL);
   assign out_valid = (count_q != 2'd0);
   assign out_instr = slot0_q.instr;
   assign out_addr  = slot0_q.addr;

   assign accept    = in_valid && in_ready;
   assign push      = accept && legal;
   assign pop       = out_valid && out_ready;
   assign addr_cur  = addr_rst ? BASE_ADDR : addr_q;
   assign new_entry = {enc, addr_cur};
   assign addr_d    = push ? addr_cur + 32'd4 : addr_cur;
   assign err_fmt_d = !clr_err && (err_fmt_q || (accept && !legal));
   assign err_imm_d = !clr_err && (err_imm_q || (push && imm_bad));

   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      count_d = count_q;
      if (pop) begin
         slot0_d = slot1_q;
         count_d = count_d - 2'd1;
      end
      if (push) begin
         if (count_d == 2'd0) slot0_d = new_entry;
         else                 slot1_d = new_entry;
         count_d = count_d + 2'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the two FIFO slots are reset too, since out_instr/out_addr must read 0 during reset.
         slot0_q   <= '0;
         slot1_q   <= '0;
         count_q   <= 2'd0;
         addr_q    <= BASE_ADDR;
         run_q     <= 1'b0;
         err_fmt_q <= 1'b0;
         err_imm_q <= 1'b0;
      end else begin
         slot0_q   <= slot0_d;
         slot1_q   <= slot1_d;
         count_q   <= count_d;
         addr_q    <= addr_d;
         run_q     <= 1'b1;
         err_fmt_q <= err_fmt_d;
         err_imm_q <= err_imm_d;
      end
   end

   assign err_fmt = err_fmt_q;
   assign err_imm = err_imm_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed literal cases plus randomized traffic checked every
// cycle against a queue-based model of the encoder and its FIFO.
module tb_instr_encoder;

   localparam logic [31:0] BASE = 32'hFFFF_FFF0;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic [2:0]  in_fmt = '0, in_funct3 = '0;
   logic        in_funct7b5 = 1'b0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [31:0] in_imm = '0;
   logic        out_valid, out_ready = 1'b0;
   logic [31:0] out_instr, out_addr;
   logic        err_fmt, err_imm;
   logic        clr_err = 1'b0, addr_rst = 1'b0;

   always #5 clk = ~clk;

   instr_encoder #(.BASE_ADDR(BASE), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr),
      .err_fmt(err_fmt), .err_imm(err_imm),
      .clr_err(clr_err), .addr_rst(addr_rst)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
   endtask

   // Reference encoder: assembles each format from shifted fields and plain range arithmetic.
   function automatic logic [31:0] ref_encode(input logic [31:0] fmt, f3, f7, rd, rs1, rs2,
                                              input logic [31:0] imm, output bit bad);
      int v;
      logic [31:0] w;
      v   = $signed(imm);
      bad = 0;
      w   = (rd << 7) | (f3 << 12) | (rs1 << 15);
      case (fmt)
         0: w = w | 32'h33 | (rs2 << 20) | (f7 << 30);
         1, 2: begin
            w   = w | (fmt == 1 ? 32'h13 : 32'h03) | ((imm & 32'hFFF) << 20);
            bad = (v < -2048) || (v > 2047);
         end
         3: begin
            w   = (f3 << 12) | (rs1 << 15) | (rs2 << 20) | 32'h23
                | ((imm & 32'h1F) << 7) | (((imm >> 5) & 32'h7F) << 25);
            bad = (v < -2048) || (v > 2047);
         end
         4: begin
            w   = (f3 << 12) | (rs1 << 15) | (rs2 << 20) | 32'h63
                | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 32'hF) << 8)
                | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 1) << 31);
            bad = (v < -4096) || (v > 4094) || imm[0];
         end
         default: begin
            w   = (rd << 7) | 32'h6F | (((imm >> 12) & 32'hFF) << 12)
                | (((imm >> 11) & 1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
                | (((imm >> 20) & 1) << 31);
            bad = (v < -(1 << 20)) || (v > (1 << 20) - 2) || imm[0];
         end
      endcase
      return w;
   endfunction

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_addr = BASE;
   bit          m_run = 0, m_efmt = 0, m_eimm = 0;

   always @(negedge rst) begin
      mq.delete();
      m_addr = BASE;
      m_run  = 0;
      m_efmt = 0;
      m_eimm = 0;
   end

   always @(posedge clk) begin
      bit          ready, bad, efmt, eimm;
      logic [31:0] a, w;
      if (rst) begin
         ready = m_run && (mq.size() < 2);
         a     = addr_rst ? BASE : m_addr;
         efmt  = 0;
         eimm  = 0;
         if (out_ready && mq.size() > 0) void'(mq.pop_front());
         if (in_valid && ready) begin
            if (in_fmt > 5) efmt = 1;
            else begin
               w = ref_encode(in_fmt, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm, bad);
               mq.push_back('{w, a});
               a    = a + 32'd4;
               eimm = bad;
            end
         end
         m_addr = a;
         if (clr_err) begin
            m_efmt = 0;
            m_eimm = 0;
         end else begin
            m_efmt = m_efmt | efmt;
            m_eimm = m_eimm | eimm;
         end
         m_run = 1;
      end
   end

   // Compare process: outputs are settled at every falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         check("rst_out_valid", 32'(out_valid), 0);
         check("rst_in_ready", 32'(in_ready), 0);
         check("rst_out_instr", out_instr, 0);
         check("rst_out_addr", out_addr, 0);
         check("rst_err", {30'b0, err_fmt, err_imm}, 0);
      end else begin
         check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
         check("in_ready", 32'(in_ready), 32'(m_run && mq.size() < 2));
         check("err_fmt", 32'(err_fmt), 32'(m_efmt));
         check("err_imm", 32'(err_imm), 32'(m_eimm));
         if (mq.size() > 0) begin
            check("out_instr", out_instr, mq[0].instr);
            check("out_addr", out_addr, mq[0].addr);
         end
      end
   end

   task automatic send(input logic [2:0] fmt, f3, input logic f7, input logic [4:0] rd, rs1, rs2,
                       input logic [31:0] imm);
      in_valid    = 1'b1;
      in_fmt      = fmt;
      in_funct3   = f3;
      in_funct7b5 = f7;
      in_rd       = rd;
      in_rs1      = rs1;
      in_rs2      = rs2;
      in_imm      = imm;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   initial begin
      bit          bad;
      logic [31:0] imm_pool[6];
      repeat (3) @(negedge clk);
      check("model_r", ref_encode(0, 0, 1, 3, 1, 2, 0, bad), 32'h402081B3);
      check("model_jal", ref_encode(5, 0, 0, 1, 0, 0, 32'd2048, bad), 32'h001000EF);
      #2 rst = 1'b1;
      step();
      check("ready_after_release", 32'(in_ready), 1);

      // R-type, then branch with an address reload, then JAL.
      send(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
      out_ready = 1'b1;
      step();
      check("r_instr", out_instr, 32'h402081B3);
      check("r_addr", out_addr, BASE);
      send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd8);
      addr_rst = 1'b1;
      step();
      addr_rst = 1'b0;
      check("b_instr", out_instr, 32'hFE208CE3);
      check("b_addr", out_addr, BASE);
      send(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
      step();
      check("jal_instr", out_instr, 32'h001000EF);
      check("jal_addr", out_addr, BASE + 32'd4);
      in_valid = 1'b0;

      // Backpressure: two accepted, third held off, head stable, then drained in order.
      step();
      out_ready = 1'b0;
      send(3'd1, 3'd0, 1'b0, 5'd5, 5'd6, 5'd0, 32'd1);
      step();
      check("bp_head1", out_instr, 32'h00130293);
      check("bp_addr1", out_addr, BASE + 32'd8);
      send(3'd1, 3'd0, 1'b0, 5'd5, 5'd6, 5'd0, 32'd2);
      step();
      check("bp_full_ready", 32'(in_ready), 0);
      send(3'd1, 3'd0, 1'b0, 5'd5, 5'd6, 5'd0, 32'd3);
      step();
      check("bp_still_full", 32'(in_ready), 0);
      check("bp_head_stable", out_instr, 32'h00130293);
      out_ready = 1'b1;
      step();
      check("bp_head2", out_instr, 32'h00230293);
      check("bp_addr2", out_addr, BASE + 32'd12);
      step();
      check("bp_head3", out_instr, 32'h00330293);
      check("bp_addr3", out_addr, BASE + 32'd16);
      in_valid = 1'b0;
      step();

      // Illegal format: consumed, nothing pushed, address not advanced.
      send(3'd6, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
      step();
      check("ill_no_output", 32'(out_valid), 0);
      check("ill_err_fmt", 32'(err_fmt), 1);
      send(3'd1, 3'd0, 1'b0, 5'd5, 5'd6, 5'd0, 32'd4);
      step();
      check("ill_next_addr", out_addr, BASE + 32'd20);
      in_valid = 1'b0;
      clr_err  = 1'b1;
      step();
      clr_err = 1'b0;
      check("clr_err_fmt", 32'(err_fmt), 0);

      // Immediate range errors, and clr_err winning over a same-cycle set.
      send(3'd1, 3'd0, 1'b0, 5'd5, 5'd6, 5'd0, 32'd4096);
      step();
      check("imm_i_err", 32'(err_imm), 1);
      check("imm_i_trunc", out_instr, 32'h00030293);
      in_valid = 1'b0;
      clr_err  = 1'b1;
      step();
      send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
      clr_err = 1'b1;
      step();
      check("clr_priority", 32'(err_imm), 0);
      clr_err = 1'b0;
      step();
      check("imm_b_odd_err", 32'(err_imm), 1);
      in_valid = 1'b0;
      clr_err  = 1'b1;
      step();
      clr_err = 1'b0;

      // Asynchronous reset with two entries queued.
      out_ready = 1'b0;
      send(3'd2, 3'd2, 1'b0, 5'd7, 5'd8, 5'd0, 32'd16);
      step();
      step();
      in_valid = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check("async_rst_valid", 32'(out_valid), 0);
      step();
      step();
      #1 rst = 1'b1;
      step();
      out_ready = 1'b1;
      send(3'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
      step();
      check("post_rst_addr", out_addr, BASE);
      in_valid = 1'b0;

      // Randomized traffic; the compare process checks every cycle.
      imm_pool = '{32'd0, 32'd2047, -32'sd2048, 32'd4094, -32'sd4096, 32'd1048574};
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] imm;
         case ($urandom_range(3))
            0: imm = $urandom_range(4000) - 2000;
            1: imm = imm_pool[$urandom_range(5)] + $urandom_range(2) - 1;
            2: imm = $urandom_range(2200000) - 1100000;
            default: imm = $urandom;
         endcase
         in_valid    = ($urandom_range(3) != 0);
         in_fmt      = ($urandom_range(9) == 0) ? 3'(6 + $urandom_range(1)) : 3'($urandom_range(5));
         in_funct3   = 3'($urandom);
         in_funct7b5 = 1'($urandom);
         in_rd       = 5'($urandom);
         in_rs1      = 5'($urandom);
         in_rs2      = 5'($urandom);
         in_imm      = imm;
         out_ready   = ($urandom_range(2) != 0);
         addr_rst    = ($urandom_range(60) == 0);
         clr_err     = ($urandom_range(30) == 0);
         step();
      end
      in_valid = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
